// File: rtl/diag_pkg.sv
// Shared state type and diagonal geometry helpers for the diagonal matrix builder.
package diag_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD
    } state_t;

    // First row touched by diagonal k (sub-diagonals start further down).
    function automatic int diag_r0(input int k);
        return (k < 0) ? -k : 0;
    endfunction

    // First column touched by diagonal k (super-diagonals start further right).
    function automatic int diag_c0(input int k);
        return (k > 0) ? k : 0;
    endfunction

    // Number of cells on diagonal k; zero when k falls outside the matrix.
    function automatic int diag_len(input int k, input int rows, input int cols);
        int rlen;
        int clen;
        if ((k < -(rows - 1)) || (k > (cols - 1)))
            return 0;
        rlen = rows - diag_r0(k);
        clen = cols - diag_c0(k);
        return (rlen < clen) ? rlen : clen;
    endfunction

    // Bit offset of element (i,j) in the row-major flattened matrix.
    function automatic int elem_lsb(input int i, input int j, input int cols, input int bit_width);
        return ((i * cols) + j) * bit_width;
    endfunction

endpackage

// File: rtl/diag_position_counter.sv
// Walks the (row,col) position along the selected diagonal and flags the last cell.
module diag_position_counter #(
    parameter int ROW_W = 4,
    parameter int COL_W = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [ROW_W-1:0] r0,
    input  logic [COL_W-1:0] c0,
    input  logic [CNT_W-1:0] len,
    input  logic             advance,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last
);

    logic [CNT_W-1:0] n;
    logic [CNT_W-1:0] len_q;

    // Latch the diagonal start and length, then step one cell per advance without wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            row   <= '0;
            col   <= '0;
            n     <= '0;
            len_q <= '0;
        end else if (load) begin
            row   <= r0;
            col   <= c0;
            n     <= '0;
            len_q <= len;
        end else if (advance && !last) begin
            row <= row + ROW_W'(1);
            col <= col + COL_W'(1);
            n   <= n + CNT_W'(1);
        end
    end

    assign last = ((n + CNT_W'(1)) == len_q);

endmodule

// File: rtl/diag_matrix_builder.sv
// Builds a matrix that is zero except on one selectable diagonal, filled from an element stream.
module diag_matrix_builder
    import diag_pkg::*;
#(
    parameter int BIT_WIDTH = 4,
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int OFF_W     = $clog2((ROWS > COLS) ? ROWS : COLS) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic signed [OFF_W-1:0]        cfg_offset,
    input  logic                           cfg_broadcast,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [BIT_WIDTH-1:0]           in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ROWS*COLS*BIT_WIDTH-1:0] out_data
);

    localparam int MIN_RC = (ROWS < COLS) ? ROWS : COLS;
    localparam int CNT_W  = $clog2(MIN_RC) + 1;
    localparam int ROW_W  = $clog2(ROWS + 1);
    localparam int COL_W  = $clog2(COLS + 1);

    state_t                  state;
    logic signed [OFF_W-1:0] k_q;
    logic                    bcast_q;
    int                      k_in;
    logic [ROW_W-1:0]        r0_in;
    logic [COL_W-1:0]        c0_in;
    logic [CNT_W-1:0]        len_in;
    logic [ROW_W-1:0]        row;
    logic [COL_W-1:0]        col;
    logic                    pos_last;
    logic                    cfg_fire;
    logic                    in_fire;
    logic                    out_fire;

    assign cfg_fire = cfg_valid && cfg_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    assign k_in   = int'(cfg_offset);
    assign r0_in  = ROW_W'(diag_r0(k_in));
    assign c0_in  = COL_W'(diag_c0(k_in));
    assign len_in = CNT_W'(diag_len(k_in, ROWS, COLS));

    diag_position_counter #(
        .ROW_W(ROW_W),
        .COL_W(COL_W),
        .CNT_W(CNT_W)
    ) u_pos (
        .clk    (clk),
        .rst    (rst),
        .load   (cfg_fire),
        .r0     (r0_in),
        .c0     (c0_in),
        .len    (len_in),
        .advance(in_fire && !bcast_q),
        .row    (row),
        .col    (col),
        .last   (pos_last)
    );

    // Sequence configure -> load -> hold with all handshake outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cfg_ready <= 1'b1;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            k_q       <= '0;
            bcast_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_fire) begin
                        k_q       <= cfg_offset;
                        bcast_q   <= cfg_broadcast;
                        cfg_ready <= 1'b0;
                        if (len_in == '0) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end else begin
                            state    <= LOAD;
                            in_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (in_fire && (bcast_q || pos_last)) begin
                        state     <= HOLD;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_fire) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        cfg_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b1;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Clear the matrix on a new config, then write either one cell or the whole diagonal per element.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
        end else if (cfg_fire) begin
            out_data <= '0;
        end else if (in_fire) begin
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    if (bcast_q ? ((j - i) == int'(k_q))
                                : ((ROW_W'(i) == row) && (COL_W'(j) == col))) begin
                        out_data[elem_lsb(i, j, COLS, BIT_WIDTH) +: BIT_WIDTH] <= in_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_diag_matrix_builder.sv
// Self-checking bench for diag_matrix_builder: behavioural model plus directed and random traffic.
`timescale 1ns/1ps
module tb_diag_matrix_builder;

    localparam int BW  = 4;
    localparam int R   = 8;
    localparam int C   = 8;
    localparam int OW  = 5;
    localparam int SR  = 4;
    localparam int SC  = 6;
    localparam int SOW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [OW-1:0]  cfg_offset = '0;
    logic           cfg_broadcast = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [BW-1:0]  in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [R*C*BW-1:0] out_data;

    logic            s_rst = 1'b1;
    logic            s_cfg_valid = 1'b0;
    logic            s_cfg_ready;
    logic [SOW-1:0]  s_cfg_offset = '0;
    logic            s_cfg_broadcast = 1'b0;
    logic            s_in_valid = 1'b0;
    logic            s_in_ready;
    logic [BW-1:0]   s_in_data = '0;
    logic            s_out_valid;
    logic            s_out_ready = 1'b0;
    logic [SR*SC*BW-1:0] s_out_data;

    int n_compared = 0;
    int n_mismatched = 0;

    // Model state: 0 = waiting for config, 1 = collecting elements, 2 = presenting matrix.
    int  mphase = 0;
    int  mk = 0;
    bit  mbcast = 1'b0;
    int  mlen = 0;
    int  mn = 0;
    int  exp_m[R][C];
    int  cfg_count = 0;
    int  in_count = 0;
    bit  model_live = 1'b0;
    bit  data_known = 1'b0;

    logic [R*C*BW-1:0] exp1;
    logic [R*C*BW-1:0] exp2;
    logic [R*C*BW-1:0] exp5;
    logic [R*C*BW-1:0] exp6;
    logic [SR*SC*BW-1:0] exp3;

    always #5 clk = ~clk;

    diag_matrix_builder #(.BIT_WIDTH(BW), .ROWS(R), .COLS(C), .OFF_W(OW)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_offset(cfg_offset), .cfg_broadcast(cfg_broadcast),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    diag_matrix_builder #(.BIT_WIDTH(BW), .ROWS(SR), .COLS(SC), .OFF_W(SOW)) dut_small (
        .clk(clk), .rst(s_rst),
        .cfg_valid(s_cfg_valid), .cfg_ready(s_cfg_ready), .cfg_offset(s_cfg_offset), .cfg_broadcast(s_cfg_broadcast),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data)
    );

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL %s: got timeout, required handshake progress", name);
    endtask

    function automatic logic [R*C*BW-1:0] model_vec();
        logic [R*C*BW-1:0] v;
        v = '0;
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++)
                v[(i*C+j)*BW +: BW] = BW'(exp_m[i][j]);
        return v;
    endfunction

    // Behavioural reference: diagonal cells are those with col - row == k, filled in row order.
    always @(posedge clk) begin
        if (rst) begin
            mphase = 0;
            mn = 0;
            data_known = 1'b1;
            model_live = 1'b1;
            for (int i = 0; i < R; i++)
                for (int j = 0; j < C; j++)
                    exp_m[i][j] = 0;
        end else begin
            case (mphase)
                0: if (cfg_valid) begin
                    mk = int'($signed(cfg_offset));
                    mbcast = cfg_broadcast;
                    mlen = 0;
                    mn = 0;
                    for (int i = 0; i < R; i++)
                        for (int j = 0; j < C; j++) begin
                            exp_m[i][j] = 0;
                            if (j - i == mk) mlen++;
                        end
                    cfg_count++;
                    mphase = (mlen == 0) ? 2 : 1;
                    data_known = (mlen == 0);
                end
                1: if (in_valid) begin
                    int idx;
                    idx = 0;
                    in_count++;
                    for (int i = 0; i < R; i++)
                        for (int j = 0; j < C; j++)
                            if (j - i == mk) begin
                                if (mbcast || idx == mn) exp_m[i][j] = int'(in_data);
                                idx++;
                            end
                    mn++;
                    if (mbcast || mn == mlen) begin
                        mphase = 2;
                        data_known = 1'b1;
                    end
                end
                default: if (out_ready) begin
                    mphase = 0;
                    data_known = 1'b0;
                end
            endcase
        end
    end

    // Compare every cycle on the falling edge against the model.
    always @(negedge clk) begin
        if (model_live) begin
            checkOutput("cfg_ready", {255'd0, cfg_ready}, {255'd0, mphase == 0});
            checkOutput("in_ready", {255'd0, in_ready}, {255'd0, mphase == 1});
            checkOutput("out_valid", {255'd0, out_valid}, {255'd0, mphase == 2});
            if (data_known) checkOutput("out_data", out_data, model_vec());
        end
    end

    task automatic do_cfg(input int k, input bit bcast);
        int target;
        int guard;
        target = cfg_count + 1;
        guard = 0;
        cfg_offset = OW'(k);
        cfg_broadcast = bcast;
        cfg_valid = 1'b1;
        in_valid = 1'($urandom_range(0, 1));
        while ((cfg_count < target) && (guard < 50)) begin
            @(posedge clk); #1;
            guard++;
        end
        cfg_valid = 1'b0;
        in_valid = 1'b0;
        cfg_offset = OW'($urandom_range(0, 31));
        cfg_broadcast = 1'($urandom_range(0, 1));
        if (cfg_count < target) timeout_fail("cfg_wait");
    endtask

    task automatic do_feed(input int data_mode, input int gap_pct);
        int guard;
        guard = 0;
        while ((mphase == 1) && (guard < 500)) begin
            in_valid = ($urandom_range(0, 99) >= gap_pct);
            if (data_mode == -2) in_data = BW'(mn + 1);
            else if (data_mode == -1) in_data = BW'($urandom_range(0, 15));
            else in_data = BW'(data_mode);
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        if (mphase == 1) timeout_fail("feed_wait");
    endtask

    task automatic do_drain(input int ready_pct);
        int guard;
        guard = 0;
        while ((mphase == 2) && (guard < 500)) begin
            out_ready = ($urandom_range(0, 99) < ready_pct);
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            guard++;
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        if (mphase == 2) timeout_fail("drain_wait");
    endtask

    task automatic applyStimulus(input int k, input bit bcast, input int data_mode, input int gap_pct, input int ready_pct);
        do_cfg(k, bcast);
        do_feed(data_mode, gap_pct);
        do_drain(ready_pct);
    endtask

    initial begin
        exp1 = '0; exp2 = '0; exp5 = '0; exp6 = '0; exp3 = '0;
        for (int n = 0; n < 8; n++) exp1[(n*C+n)*BW +: BW] = BW'(n + 1);
        for (int n = 0; n < 5; n++) exp2[(n*C+n+3)*BW +: BW] = 4'hA;
        for (int n = 0; n < 7; n++) exp5[(n*C+n+1)*BW +: BW] = BW'(n + 1);
        for (int n = 0; n < 7; n++) exp6[((n+1)*C+n)*BW +: BW] = BW'(n + 1);
        exp3[48 +: BW] = 4'h5;
        exp3[76 +: BW] = 4'h6;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        s_rst = 1'b0;
        checkOutput("reset_cfg_ready", {255'd0, cfg_ready}, 256'd1);
        checkOutput("reset_in_ready", {255'd0, in_ready}, 256'd0);
        checkOutput("reset_out_valid", {255'd0, out_valid}, 256'd0);
        checkOutput("reset_out_data", out_data, 256'd0);

        // 4x6 matrix, k=-2, two elements
        s_cfg_valid = 1'b1;
        s_cfg_offset = 4'b1110;
        s_cfg_broadcast = 1'b0;
        @(posedge clk); #1;
        s_cfg_valid = 1'b0;
        checkOutput("t3_in_ready", {255'd0, s_in_ready}, 256'd1);
        checkOutput("t3_cfg_ready", {255'd0, s_cfg_ready}, 256'd0);
        s_in_valid = 1'b1;
        s_in_data = 4'h5;
        @(posedge clk); #1;
        checkOutput("t3_not_valid_yet", {255'd0, s_out_valid}, 256'd0);
        s_in_data = 4'h6;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        checkOutput("t3_out_valid", {255'd0, s_out_valid}, 256'd1);
        checkOutput("t3_in_ready_drop", {255'd0, s_in_ready}, 256'd0);
        checkOutput("t3_out_data", {160'd0, s_out_data}, {160'd0, exp3});
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
        checkOutput("t3_out_valid_drop", {255'd0, s_out_valid}, 256'd0);
        checkOutput("t3_cfg_ready_back", {255'd0, s_cfg_ready}, 256'd1);

        // main diagonal, per-element 1..8
        do_cfg(0, 1'b0);
        do_feed(-2, 0);
        checkOutput("t1_out_valid", {255'd0, out_valid}, 256'd1);
        checkOutput("t1_out_data", out_data, exp1);
        do_drain(100);

        // k=+3 broadcast 0xA; further inputs must not be consumed
        do_cfg(3, 1'b1);
        in_valid = 1'b1;
        in_data = 4'hA;
        @(posedge clk); #1;
        checkOutput("t2_out_valid", {255'd0, out_valid}, 256'd1);
        repeat (3) begin
            in_data = 4'h5;
            @(posedge clk); #1;
            checkOutput("t2_out_data", out_data, exp2);
            checkOutput("t2_in_ready", {255'd0, in_ready}, 256'd0);
        end
        in_valid = 1'b0;
        do_drain(100);

        // out-of-range offsets give an empty diagonal
        do_cfg(8, 1'b0);
        checkOutput("t4_pos_out_valid", {255'd0, out_valid}, 256'd1);
        checkOutput("t4_pos_in_ready", {255'd0, in_ready}, 256'd0);
        checkOutput("t4_pos_out_data", out_data, 256'd0);
        do_drain(100);
        do_cfg(-8, 1'b1);
        checkOutput("t4_neg_out_valid", {255'd0, out_valid}, 256'd1);
        checkOutput("t4_neg_out_data", out_data, 256'd0);
        do_drain(100);
        do_cfg(-16, 1'b1);
        checkOutput("t4_min_out_valid", {255'd0, out_valid}, 256'd1);
        checkOutput("t4_min_in_ready", {255'd0, in_ready}, 256'd0);
        do_drain(50);

        // backpressure with in_valid and cfg_valid held high
        do_cfg(1, 1'b0);
        do_feed(-2, 25);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 4'hF;
        cfg_valid = 1'b1;
        cfg_offset = '0;
        cfg_broadcast = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            checkOutput("t5_out_data", out_data, exp5);
            checkOutput("t5_cfg_ready", {255'd0, cfg_ready}, 256'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("t5_out_valid_drop", {255'd0, out_valid}, 256'd0);
        checkOutput("t5_cfg_ready_bubble", {255'd0, cfg_ready}, 256'd1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        checkOutput("t5_next_cfg_taken", {255'd0, in_ready}, 256'd1);

        // reset after 3 of 8 elements, then a fresh clean matrix
        for (int e = 0; e < 3; e++) begin
            in_data = BW'(e + 7);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("t6_out_valid", {255'd0, out_valid}, 256'd0);
        checkOutput("t6_out_data", out_data, 256'd0);
        checkOutput("t6_cfg_ready", {255'd0, cfg_ready}, 256'd1);
        checkOutput("t6_in_ready", {255'd0, in_ready}, 256'd0);
        do_cfg(-1, 1'b0);
        do_feed(-2, 30);
        checkOutput("t6_clean", out_data, exp6);
        do_drain(60);

        // randomized traffic
        for (int t = 0; t < 30; t++) begin
            applyStimulus($urandom_range(0, 31) - 16, 1'($urandom_range(0, 1)), -1, 30, 50);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/diag_matrix_builder.md
Name: diag_matrix_builder

Overview:
- Sequential successor to the combinational diagonal-array generator.
- Builds a ROWS x COLS matrix that is zero everywhere except one selectable diagonal (main, super or sub).
- The diagonal is filled from an element stream, either one value per position or one value broadcast to every position.
- Presents the finished matrix flattened on a valid/ready output. Sits between a scalar/vector producer and matrix-consuming array operators.

Parameters:
- BIT_WIDTH, 4, element width in bits.
- ROWS, 8, matrix rows.
- COLS, 8, matrix columns.
- OFF_W, $clog2(ROWS>COLS?ROWS:COLS)+1, width of the signed diagonal offset.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration accepted when cfg_valid && cfg_ready.
- cfg_offset  in  OFF_W (signed)  diagonal offset k: 0 = main, >0 = super, <0 = sub.
- cfg_broadcast  in  1  1 = one element fills the whole diagonal; 0 = one element per diagonal position.
- in_valid  in  1  element valid.
- in_ready  out  1  element accepted when in_valid && in_ready.
- in_data  in  BIT_WIDTH  diagonal element.
- out_valid  out  1  matrix valid.
- out_ready  in  1  consumer accepts the matrix.
- out_data  out  ROWS*COLS*BIT_WIDTH  element (i,j) at bits [(i*COLS+j)*BIT_WIDTH +: BIT_WIDTH].

Behaviour:
- Reset: state=IDLE, cfg_ready=1, in_ready=0, out_valid=0, out_data=0, counters=0. Reset mid-LOAD or mid-HOLD discards the partial or held matrix with no output.
- Diagonal geometry:
  - r0 = max(0,-k), c0 = max(0,k).
  - LEN = min(ROWS-r0, COLS-c0) when -(ROWS-1) <= k <= COLS-1; otherwise LEN = 0.
  - Element n (0-based) is written to (r0+n, c0+n).
- States:
  - IDLE: cfg_ready=1. On the cfg handshake: latch k, the broadcast flag and LEN; clear the matrix register. Go to HOLD if LEN==0, else go to LOAD.
  - LOAD: in_ready=1, cfg_ready=0.
    - Each element handshake writes the element at the current position and increments n.
    - Broadcast mode: the first and only handshake writes in_data to all LEN positions in that same cycle, then goes to HOLD.
    - Per-element mode: the handshake with n==LEN-1 goes to HOLD.
  - HOLD: out_valid=1, in_ready=0, cfg_ready=0. out_data stays stable until out_ready. The out handshake goes to IDLE; out_valid drops the next cycle.
- Latency:
  - out_valid rises the cycle after the last element handshake.
  - For LEN==0, out_valid rises the cycle after the cfg handshake.
  - There is one IDLE bubble between the out handshake and the next cfg acceptance.
- Boundaries:
  - in_valid in IDLE/HOLD is ignored and not consumed.
  - Gaps in in_valid during LOAD stall only; no timeout.
  - out_ready held low holds HOLD indefinitely.
  - Off-diagonal elements are always 0.
  - cfg_offset is sign-interpreted, so the most negative value yields LEN=0.
  - The counter n never exceeds LEN-1; no wrap.
- Widths:
  - Counter width $clog2(min(ROWS,COLS))+1.
  - Offset comparisons are done in signed arithmetic extended to at least OFF_W+1 bits.

Decomposition:
- Package diag_pkg:
  - state enum {IDLE, LOAD, HOLD}.
  - Function diag_len(k, ROWS, COLS).
  - Functions diag_r0/diag_c0.
  - Flat-index helper elem_lsb(i,j,COLS,BIT_WIDTH).
- Sub-module diag_position_counter:
  - Latches r0/c0/LEN.
  - Steps (row,col) on an advance pulse.
  - Flags last.
- Top level holds the FSM, handshakes and matrix register.

Test Plan:
1. ROWS=COLS=8, BIT_WIDTH=4, k=0, per-element, stream 1..8 -> out_data has (i,i)=i+1 and all other cells 0; out_valid the cycle after the 8th handshake.
2. k=+3, broadcast, in_data=0xA -> LEN=5; (0,3),(1,4),(2,5),(3,6),(4,7)=0xA, all other cells 0; exactly one input consumed.
3. ROWS=4, COLS=6, k=-2, per-element, stream 5,6 -> (2,0)=5, (3,1)=6; out_valid after the 2nd element.
4. k=8 (OFF_W=5) or k=-8 -> LEN=0; out_data all zero; out_valid the cycle after cfg accept; in_ready never asserted.
5. Backpressure: out_ready low for 10 cycles, in_valid and cfg_valid held high -> out_data stable; no input consumed; cfg_ready=0 until one cycle after the out handshake.
6. Assert rst after 3 of 8 elements in LOAD -> next cycle state IDLE, out_valid=0, out_data=0; a fresh config produces a clean matrix with no stale elements.
